// File: rtl/mbist_mem_model.sv
`default_nettype none
// ============================================================================
//  Module   : mbist_mem_model
//  Purpose  : Bit-wide single-port SRAM responder for a BIST controller, with
//             a latched fault-injection configuration (stuck-at-0/1, rising
//             transition, coupling) and saturating access counters.
//  Ports    : clk, rst_n (sync, active-low)
//             mode          - 1 selects the BIST port, 0 the functional port
//             cs/we/oe_bist, mem_addr, mem_pattern - BIST access port
//             func_cs/we/oe, func_addr, func_d_in  - functional access port
//             mem_d_out     - registered read data (latency 1)
//             fi_load, fi_en, fi_type, fi_victim, fi_aggr - fault config
//             rd_cnt, wr_cnt - saturating 16-bit access counters
//  Revision : 1.0 - initial release
// ============================================================================
module mbist_mem_model #(
  parameter int ADDR = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic            cs_bist,
  input  logic            we_bist,
  input  logic            oe_bist,
  input  logic [ADDR-1:0] mem_addr,
  input  logic            mem_pattern,
  input  logic            func_cs,
  input  logic            func_we,
  input  logic            func_oe,
  input  logic [ADDR-1:0] func_addr,
  input  logic            func_d_in,
  output logic            mem_d_out,
  input  logic            fi_load,
  input  logic            fi_en,
  input  logic [1:0]      fi_type,
  input  logic [ADDR-1:0] fi_victim,
  input  logic [ADDR-1:0] fi_aggr,
  output logic [15:0]     rd_cnt,
  output logic [15:0]     wr_cnt
);

  localparam int         DEPTH   = 1 << ADDR;
  localparam logic [1:0] FT_TF   = 2'b10;
  localparam logic [1:0] FT_CF   = 2'b11;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Storage and registered outputs
  logic [DEPTH-1:0] mem_q, mem_d;
  logic             dout_q, dout_d;
  logic [15:0]      rd_cnt_q, rd_cnt_d;
  logic [15:0]      wr_cnt_q, wr_cnt_d;

  // Latched fault configuration
  logic             fi_en_q;
  logic [1:0]       fi_type_q;
  logic [ADDR-1:0]  fi_victim_q;
  logic [ADDR-1:0]  fi_aggr_q;

  // Selected access port
  logic             sel_cs, sel_we, sel_oe, sel_din;
  logic [ADDR-1:0]  sel_addr;

  // Fault qualifiers
  logic             stuck_act;
  logic             tf_block;
  logic             cf_fire;
  logic             rd_val;

  assign sel_cs   = mode ? cs_bist     : func_cs;
  assign sel_we   = mode ? we_bist     : func_we;
  assign sel_oe   = mode ? oe_bist     : func_oe;
  assign sel_addr = mode ? mem_addr    : func_addr;
  assign sel_din  = mode ? mem_pattern : func_d_in;

  // Types 00/01 are stuck-at; bit 0 of the type is the stuck value.
  assign stuck_act = fi_en_q && !fi_type_q[1];

  // Rising transition on the victim is swallowed.
  assign tf_block = fi_en_q && (fi_type_q == FT_TF) && (sel_addr == fi_victim_q)
                    && sel_din && !mem_q[fi_victim_q];

  // Aggressor 0->1 write flips the victim; a self-coupled cell is ignored.
  assign cf_fire = fi_en_q && (fi_type_q == FT_CF) && (sel_addr == fi_aggr_q)
                   && (fi_aggr_q != fi_victim_q) && sel_din && !mem_q[fi_aggr_q];

  // The stuck value is returned even before the cell itself has been forced,
  // i.e. on the first cycle after the configuration is loaded.
  assign rd_val = (stuck_act && (sel_addr == fi_victim_q)) ? fi_type_q[0]
                                                           : mem_q[sel_addr];

  always_comb begin
    mem_d    = mem_q;
    dout_d   = dout_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (sel_cs && sel_we) begin
      if (!tf_block) begin
        mem_d[sel_addr] = sel_din;
      end
      if (cf_fire) begin
        mem_d[fi_victim_q] = ~mem_q[fi_victim_q];
      end
      if (wr_cnt_q != CNT_MAX) begin
        wr_cnt_d = wr_cnt_q + 16'd1;
      end
    end else if (sel_cs && sel_oe) begin
      dout_d = rd_val;
      if (rd_cnt_q != CNT_MAX) begin
        rd_cnt_d = rd_cnt_q + 16'd1;
      end
    end
    // Applied last so a stuck victim wins over any write or coupling flip.
    if (stuck_act) begin
      mem_d[fi_victim_q] = fi_type_q[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q       <= '0;
      dout_q      <= 1'b0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      fi_en_q     <= 1'b0;
      fi_type_q   <= '0;
      fi_victim_q <= '0;
      fi_aggr_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      dout_q   <= dout_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      if (fi_load) begin
        fi_en_q     <= fi_en;
        fi_type_q   <= fi_type;
        fi_victim_q <= fi_victim;
        fi_aggr_q   <= fi_aggr;
      end
    end
  end

  assign mem_d_out = dout_q;
  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;

endmodule
`default_nettype wire
